// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: major opcodes, ex_op classes, immediate formats.
// Also the default datapath width and the DEC/EX control bundle layout.
package decode_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    EX_NOP     = 4'd0,
    EX_OP      = 4'd1,
    EX_OP_IMM  = 4'd2,
    EX_LOAD    = 4'd3,
    EX_STORE   = 4'd4,
    EX_BRANCH  = 4'd5,
    EX_JAL     = 4'd6,
    EX_JALR    = 4'd7,
    EX_LUI     = 4'd8,
    EX_AUIPC   = 4'd9,
    EX_ILLEGAL = 4'd10
  } ex_op_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    ex_op_t     op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       funct7b5;
  } dec_ctl_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// Integer register file, 2 combinational reads, 1 write at clk; x0 reads zero.
// Option: DECODE_WB_BYPASS_EN returns the in-flight write data on a matching read.
module reg_file_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && rd != 5'd0) begin
      regs[rd] <= wd;
    end
  end

  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (we && rd != 5'd0 && rd == rs1) rs1_val = wd;
    if (we && rd != 5'd0 && rd == rs2) rs2_val = wd;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: operand read, immediate generation, registered DEC/EX bundle.
// Latency 1 cycle; dec_ready drops on !ex_ready or load-use hazard, flush overrides both.
// Option: DECODE_WB_BYPASS_EN makes same-cycle writeback visible to operand reads.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc4,
  output logic            dec_ready,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_op,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5
);

  dec_ctl_t        d_ctl;
  dec_ctl_t        ex_ctl;
  imm_fmt_t        d_fmt;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            has_rd;
  logic            hazard;
  logic [XLEN-1:0] d_imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    d_ctl    = '0;
    d_ctl.op = EX_ILLEGAL;
    d_fmt    = IMM_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    has_rd   = 1'b0;
    case (if_instr[6:0])
      OPC_OP:     begin d_ctl.op = EX_OP;                        uses_rs1 = 1'b1; uses_rs2 = 1'b1; has_rd = 1'b1; end
      OPC_OP_IMM: begin d_ctl.op = EX_OP_IMM; d_fmt = IMM_I;     uses_rs1 = 1'b1; has_rd = 1'b1; end
      OPC_LOAD:   begin d_ctl.op = EX_LOAD;   d_fmt = IMM_I;     uses_rs1 = 1'b1; has_rd = 1'b1; end
      OPC_STORE:  begin d_ctl.op = EX_STORE;  d_fmt = IMM_S;     uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_BRANCH: begin d_ctl.op = EX_BRANCH; d_fmt = IMM_B;     uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_JAL:    begin d_ctl.op = EX_JAL;    d_fmt = IMM_J;     has_rd = 1'b1; end
      OPC_JALR:   begin d_ctl.op = EX_JALR;   d_fmt = IMM_I;     uses_rs1 = 1'b1; has_rd = 1'b1; end
      OPC_LUI:    begin d_ctl.op = EX_LUI;    d_fmt = IMM_U;     has_rd = 1'b1; end
      OPC_AUIPC:  begin d_ctl.op = EX_AUIPC;  d_fmt = IMM_U;     has_rd = 1'b1; end
      default:    d_ctl.op = EX_ILLEGAL;
    endcase
    // Unused register fields are zeroed so they never alias a real hazard or read.
    d_ctl.rs1      = uses_rs1 ? if_instr[19:15] : 5'd0;
    d_ctl.rs2      = uses_rs2 ? if_instr[24:20] : 5'd0;
    d_ctl.rd       = has_rd   ? if_instr[11:7]  : 5'd0;
    d_ctl.funct3   = if_instr[14:12];
    d_ctl.funct7b5 = if_instr[30];
  end

  always_comb begin
    d_imm = '0;
    case (d_fmt)
      IMM_I:   d_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      IMM_S:   d_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      IMM_B:   d_imm = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
      IMM_U:   d_imm = {{(XLEN-31){if_instr[31]}}, if_instr[30:12], 12'b0};
      IMM_J:   d_imm = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
      default: d_imm = '0;
    endcase
  end

  reg_file_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .rs1     (d_ctl.rs1),
    .rs2     (d_ctl.rs2),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .we      (wb_we),
    .rd      (wb_rd),
    .wd      (wb_data)
  );

  assign hazard = ex_valid && (ex_ctl.op == EX_LOAD) && (ex_ctl.rd != 5'd0) &&
                  ((uses_rs1 && d_ctl.rs1 == ex_ctl.rd) || (uses_rs2 && d_ctl.rs2 == ex_ctl.rd));

  // A flushed instruction is consumed (discarded), so IF may advance.
  assign dec_ready = flush || (ex_ready && !hazard);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid   <= 1'b0;
      ex_ctl     <= '0;
      ex_pc      <= '0;
      ex_pc4     <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_ready) begin
      if (hazard) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid   <= if_valid;
        ex_ctl     <= d_ctl;
        ex_pc      <= if_pc;
        ex_pc4     <= if_pc4;
        ex_rs1_val <= rs1_val;
        ex_rs2_val <= rs2_val;
        ex_imm     <= d_imm;
      end
    end
  end

  assign ex_op       = ex_ctl.op;
  assign ex_rs1      = ex_ctl.rs1;
  assign ex_rs2      = ex_ctl.rs2;
  assign ex_rd       = ex_ctl.rd;
  assign ex_funct3   = ex_ctl.funct3;
  assign ex_funct7b5 = ex_ctl.funct7b5;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions with hand-decoded expectations.
// Build with or without DECODE_WB_BYPASS_EN; the bypass expectation follows the macro.
module tb_decode_stage;

  localparam logic [3:0] T_NOP = 4'd0, T_OP = 4'd1, T_OP_IMM = 4'd2, T_LOAD = 4'd3,
                         T_STORE = 4'd4, T_BRANCH = 4'd5, T_JAL = 4'd6,
                         T_LUI = 4'd8, T_AUIPC = 4'd9, T_ILLEGAL = 4'd10;
`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] X7_SAME_CYCLE = 32'h0000_1234;
`else
  localparam logic [31:0] X7_SAME_CYCLE = 32'h0000_1111;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc, if_instr, if_pc4;
  logic        dec_ready, flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_pc4, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;

  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk (clk), .reset (reset),
    .if_valid (if_valid), .if_pc (if_pc), .if_instr (if_instr), .if_pc4 (if_pc4),
    .dec_ready (dec_ready), .flush (flush),
    .wb_we (wb_we), .wb_rd (wb_rd), .wb_data (wb_data),
    .ex_ready (ex_ready), .ex_valid (ex_valid),
    .ex_pc (ex_pc), .ex_pc4 (ex_pc4), .ex_rs1_val (ex_rs1_val), .ex_rs2_val (ex_rs2_val),
    .ex_imm (ex_imm), .ex_rs1 (ex_rs1), .ex_rs2 (ex_rs2), .ex_rd (ex_rd),
    .ex_op (ex_op), .ex_funct3 (ex_funct3), .ex_funct7b5 (ex_funct7b5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] rs1v,
                      input logic [31:0] rs2v, input logic [31:0] imm, input logic [2:0] f3,
                      input logic f7b5);
    exp_t e;
    e.pc = pc; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.rs1v = rs1v; e.rs2v = rs2v; e.imm = imm; e.f3 = f3; e.f7b5 = f7b5;
    exp_q.push_back(e);
  endtask

  // One cycle: apply inputs after the edge, check mid-cycle, return just after the next edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic er, input logic exp_rdy, input int exp_v);
    if_valid = v; if_instr = ins; if_pc = pc; if_pc4 = pc + 32'd4; flush = fl; ex_ready = er;
    @(negedge clk);
    chk("dec_ready", 32'(dec_ready), 32'(exp_rdy));
    if (exp_v >= 0) chk("ex_valid", 32'(ex_valid), 32'(exp_v));
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output pc=0x%08h op=%0d required=none", ex_pc, ex_op);
        end else begin
          e = exp_q.pop_front();
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_pc4", ex_pc4, e.pc + 32'd4);
          chk("ex_op", 32'(ex_op), 32'(e.op));
          chk("ex_rd", 32'(ex_rd), 32'(e.rd));
          chk("ex_rs1", 32'(ex_rs1), 32'(e.rs1));
          chk("ex_rs2", 32'(ex_rs2), 32'(e.rs2));
          chk("ex_rs1_val", ex_rs1_val, e.rs1v);
          chk("ex_rs2_val", ex_rs2_val, e.rs2v);
          chk("ex_imm", ex_imm, e.imm);
          chk("ex_funct3", 32'(ex_funct3), 32'(e.f3));
          chk("ex_funct7b5", 32'(ex_funct7b5), 32'(e.f7b5));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; if_pc4 = '0;
    flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_op", 32'(ex_op), 32'(T_NOP));
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Preload x1, x2, x5, x7 through the writeback port.
    wb_we = 1'b1;
    wb_rd = 5'd1; wb_data = 32'h10;   drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    wb_rd = 5'd2; wb_data = 32'h22;   drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, -1);
    wb_rd = 5'd5; wb_data = 32'h55;   drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, -1);
    wb_rd = 5'd7; wb_data = 32'h1111; drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, -1);
    wb_we = 1'b0;

    // addi x1,x0,-5
    push(32'h1000, T_OP_IMM, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFB, 3'd0, 1'b1);
    drive(1'b1, 32'hFFB0_0093, 32'h1000, 1'b0, 1'b1, 1'b1, 0);
    // lw x2,0(x1) then add x3,x2,x2: one stall cycle, then a bubble
    push(32'h1004, T_LOAD, 5'd2, 5'd1, 5'd0, 32'h10, 32'h0, 32'h0, 3'd2, 1'b0);
    drive(1'b1, 32'h0000_A103, 32'h1004, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b1, 32'h0021_01B3, 32'h1008, 1'b0, 1'b1, 1'b0, 1);
    push(32'h1008, T_OP, 5'd3, 5'd2, 5'd2, 32'h22, 32'h22, 32'h0, 3'd0, 1'b0);
    drive(1'b1, 32'h0021_01B3, 32'h1008, 1'b0, 1'b1, 1'b1, 0);

    // add x8,x7,x7 while x7 is being written with 0x1234
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    push(32'h100C, T_OP, 5'd8, 5'd7, 5'd7, X7_SAME_CYCLE, X7_SAME_CYCLE, 32'h0, 3'd0, 1'b0);
    drive(1'b1, 32'h0073_8433, 32'h100C, 1'b0, 1'b1, 1'b1, 1);
    wb_we = 1'b0;
    push(32'h1010, T_OP, 5'd9, 5'd7, 5'd0, 32'h1234, 32'h0, 32'h0, 3'd0, 1'b0);
    drive(1'b1, 32'h0003_84B3, 32'h1010, 1'b0, 1'b1, 1'b1, 1);

    // beq x0,x0,-8 then three cycles of EX backpressure
    push(32'h1014, T_BRANCH, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFF8, 3'd0, 1'b1);
    drive(1'b1, 32'hFE00_0CE3, 32'h1014, 1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1; if_instr = 32'h1234_55B7; if_pc = 32'h1018; if_pc4 = 32'h101C; ex_ready = 1'b0;
      @(negedge clk);
      chk("stall_dec_ready", 32'(dec_ready), 32'd0);
      chk("stall_ex_valid", 32'(ex_valid), 32'd1);
      chk("stall_ex_pc", ex_pc, exp_q[0].pc);
      chk("stall_ex_imm", ex_imm, exp_q[0].imm);
      chk("stall_ex_op", 32'(ex_op), 32'(exp_q[0].op));
      @(posedge clk);
      #1;
    end
    // lui x11,0x12345
    push(32'h1018, T_LUI, 5'd11, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1234_5000, 3'd5, 1'b0);
    drive(1'b1, 32'h1234_55B7, 32'h1018, 1'b0, 1'b1, 1'b1, 1);

    // lw x12,4(x1) then add x13,x12,x0 with flush: flush beats the hazard
    push(32'h101C, T_LOAD, 5'd12, 5'd1, 5'd0, 32'h10, 32'h0, 32'h4, 3'd2, 1'b0);
    drive(1'b1, 32'h0040_A603, 32'h101C, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b1, 32'h0006_06B3, 32'h1020, 1'b1, 1'b1, 1'b1, 1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 0);

    // illegal, jal x1,8, sw x2,-4(x1), auipc x10,0xFFFFF
    push(32'h2000, T_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd7, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 32'h2000, 1'b0, 1'b1, 1'b1, 0);
    push(32'h2004, T_JAL, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 3'd0, 1'b0);
    drive(1'b1, 32'h0080_00EF, 32'h2004, 1'b0, 1'b1, 1'b1, 1);
    push(32'h2008, T_STORE, 5'd0, 5'd1, 5'd2, 32'h10, 32'h22, 32'hFFFF_FFFC, 3'd2, 1'b1);
    drive(1'b1, 32'hFE20_AE23, 32'h2008, 1'b0, 1'b1, 1'b1, 1);
    push(32'h200C, T_AUIPC, 5'd10, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_F000, 3'd7, 1'b1);
    drive(1'b1, 32'hFFFF_F517, 32'h200C, 1'b0, 1'b1, 1'b1, 1);

    // jalr x14,0(x5) is live in DEC/EX when reset hits; it is never delivered
    drive(1'b1, 32'h0002_8767, 32'h2010, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
    chk("midrst_ex_op", 32'(ex_op), 32'(T_NOP));
    chk("midrst_ex_rd", 32'(ex_rd), 32'd0);
    chk("midrst_ex_pc", ex_pc, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    // add x15,x5,x5: x5 was cleared by reset
    push(32'h3000, T_OP, 5'd15, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    drive(1'b1, 32'h0052_87B3, 32'h3000, 1'b0, 1'b1, 1'b1, 0);

    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, -1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the TinyRISCV five-stage pipeline. Consumes the PC, instruction word and PC+4 held in the IF/DEC pipeline register and owns the 32×32 integer register file. Reads operands, generates the sign-extended immediate and classifies the RV32I opcode. Drives a registered DEC/EX bundle with valid/ready flow control, flush, and load-use stall detection.

## Interface
- XLEN, 32, datapath width
- NREG, 32, architectural registers; x0 hard-wired zero

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- if_valid  in  1  IF/DEC register holds a live instruction
- if_pc  in  XLEN  PC of the instruction
- if_instr  in  32  instruction word
- if_pc4  in  XLEN  PC+4
- dec_ready  out  1  decode accepts the instruction this cycle; IF and IF/DEC hold when 0
- flush  in  1  branch/jump redirect from EX; kill the instruction in decode
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- ex_ready  in  1  EX accepts the DEC/EX bundle
- ex_valid  out  1  DEC/EX bundle is live
- ex_pc, ex_pc4  out  XLEN  forwarded PC values
- ex_rs1_val, ex_rs2_val  out  XLEN  operand values
- ex_imm  out  XLEN  sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5  register indices (0 if unused)
- ex_op  out  4  opcode class: NOP, OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL
- ex_funct3  out  3; ex_funct7b5  out  1

## Operation
- Register file: write at posedge when wb_we && wb_rd!=0; reads combinational; x0 reads 0.
- Immediate format chosen by opcode: I (OP_IMM, LOAD, JALR), S, B, U, J; all sign-extended from bit 31; OP gives 0.
- Unknown opcode → ILLEGAL, ex_rd=0, passed to EX as valid.
- Load-use hazard: ex_valid && ex_op==LOAD && ex_rd!=0 && (uses_rs1 && rs1==ex_rd || uses_rs2 && rs2==ex_rd).
- DEC/EX register update per cycle, priority order:
  - flush → ex_valid=0 (other fields don't-care), dec_ready=1 (instruction discarded).
  - !ex_ready → all DEC/EX fields hold, dec_ready=0.
  - hazard → insert bubble (ex_valid=0), dec_ready=0.
  - else → capture decoded bundle, ex_valid=if_valid, dec_ready=1.
- dec_ready is combinational from if_instr, DEC/EX state, flush, ex_ready.

## Timing
- Latency 1: instruction accepted at edge N appears on ex_* after edge N.
- Load-use costs exactly one bubble cycle.
- Reset (async, any time): ex_valid=0, all ex_* fields 0, ex_op=NOP, register file all 0; dec_ready reflects ex_ready after release.
- Flush and hazard same cycle: flush wins, no stall.
- wb write and operand read of same register same cycle: see Configuration.

## Configuration
- DECODE_WB_BYPASS_EN defined: a read of rs1/rs2 equal to wb_rd (nonzero) while wb_we=1 returns wb_data (write-through).
- Undefined: read returns the pre-write value; the new value becomes visible one cycle later; hazard unit does not compensate.

## Structure
- decode_pkg: RV32I opcode localparams, ex_op class encoding, immediate-format encoding, XLEN default.
- Sub-module reg_file_2r1w (two read ports, one write port, async reset, bypass under the macro).

## Test plan
- Reset mid-stream with ex_valid=1 → ex_valid=0, ex_op=NOP, x5 reads 0 afterwards.
- addi x1,x0,-5 (0xFFB00093) → ex_op=OP_IMM, ex_rd=1, ex_imm=0xFFFFFFFB, next cycle ex_valid=1.
- lw x2,0(x1) followed by add x3,x2,x2 → one cycle dec_ready=0 with ex_valid=0 bubble, then add issues.
- wb_we=1, wb_rd=7, wb_data=0x1234 same cycle as read of x7 → 0x1234 with DECODE_WB_BYPASS_EN, old value without.
- ex_ready=0 for 3 cycles → ex_* stable, dec_ready=0; flush asserted with a hazard pending → ex_valid=0, dec_ready=1.
- beq with imm −8 (0xFE000CE3) → ex_op=BRANCH, ex_imm=0xFFFFFFF8, ex_rd=0.
